// File: rtl/cei_mochila_pkg.sv
// Shared limits, index type and round-robin helper for the mochila OBI arbiter.
package cei_mochila_pkg;

  localparam int unsigned ARB_MAX_MASTERS     = 8;
  localparam int unsigned ARB_MAX_OUTSTANDING = 8;

  typedef logic [2:0] arb_idx_t;

  // First requester found scanning upward from ptr, modulo n. Returns 0 when
  // nobody requests; callers qualify the result with |req.
  function automatic arb_idx_t rr_next(input logic [ARB_MAX_MASTERS-1:0] req,
                                       input arb_idx_t ptr,
                                       input int unsigned n);
    arb_idx_t    win;
    logic        found;
    int unsigned c;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < ARB_MAX_MASTERS; k++) begin
      c = 32'(ptr) + k;
      if (c >= n) c = c - n;
      if (k < n && !found && req[c[2:0]]) begin
        win   = c[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundle types shared by the bus system and memory banks.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/mochila_arb_fifo.sv
// In-order FIFO of granted master indices; the head names the master that owns
// the next read response.
module mochila_arb_fifo
  import cei_mochila_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  arb_idx_t push_idx_i,
  input  logic     pop_i,
  output arb_idx_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  arb_idx_t           mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rptr_q];

  // Pointer and occupancy bookkeeping; push and pop together keep the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= ptr_inc(wptr_q);
      if (pop_ok)  rptr_q <= ptr_inc(rptr_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage; contents are meaningless while the count says empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= push_idx_i;
  end

endmodule

// File: rtl/mochila_obi_arbiter.sv
// Round-robin arbiter sharing one OBI slave between N_MASTERS requesters.
// Responses are routed back through an in-order outstanding FIFO.
// Optional: define MOCHILA_ARB_PERF_EN to add per-master grant/stall counters.
module mochila_obi_arbiter
  import obi_pkg::*;
  import cei_mochila_pkg::*;
#(
  parameter int unsigned N_MASTERS       = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  master_req_i  [N_MASTERS],
  output obi_resp_t master_resp_o [N_MASTERS],
  output obi_req_t  slave_req_o,
  input  obi_resp_t slave_resp_i,
  output logic      err_o
`ifdef MOCHILA_ARB_PERF_EN
  ,
  output logic [31:0] grant_cnt_o [N_MASTERS],
  output logic [31:0] stall_cnt_o [N_MASTERS]
`endif
);

  arb_idx_t                   rr_ptr_q, rr_ptr_d;
  arb_idx_t                   sel;
  arb_idx_t                   head;
  logic [ARB_MAX_MASTERS-1:0] req_vec;
  logic                       sel_vld;
  logic                       hs;
  logic                       rsp_vld;
  logic                       fifo_full, fifo_empty;
  logic                       err_q, err_d;

  // Gather request bits into a fixed-width vector for the scan helper.
  always_comb begin
    req_vec = '0;
    for (int m = 0; m < N_MASTERS; m++) req_vec[m] = master_req_i[m].req;
  end

  // A full FIFO blocks selection outright, even if a response pops this cycle.
  assign sel     = rr_next(req_vec, rr_ptr_q, N_MASTERS);
  assign sel_vld = (|req_vec) & ~fifo_full;

  // Forward the selected master's request untouched; all zeros when idle.
  always_comb begin
    slave_req_o = '0;
    for (int m = 0; m < N_MASTERS; m++) begin
      if (sel_vld && sel == arb_idx_t'(m)) slave_req_o = master_req_i[m];
    end
  end

  assign hs      = slave_req_o.req & slave_resp_i.gnt;
  assign rsp_vld = slave_resp_i.rvalid & ~fifo_empty;

  // Grant goes to the selected master, response to the FIFO head only.
  always_comb begin
    for (int m = 0; m < N_MASTERS; m++) begin
      master_resp_o[m]        = '0;
      master_resp_o[m].gnt    = hs && (sel == arb_idx_t'(m));
      master_resp_o[m].rvalid = rsp_vld && (head == arb_idx_t'(m));
      master_resp_o[m].rdata  = (rsp_vld && head == arb_idx_t'(m)) ? slave_resp_i.rdata : '0;
    end
  end

  // Pointer moves past the winner on every handshake; error is sticky.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs) rr_ptr_d = (sel == arb_idx_t'(N_MASTERS - 1)) ? '0 : sel + arb_idx_t'(1);
    err_d = err_q | (slave_resp_i.rvalid & fifo_empty);
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign err_o = err_q;

  mochila_arb_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (hs),
    .push_idx_i (sel),
    .pop_i      (rsp_vld),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

`ifdef MOCHILA_ARB_PERF_EN
  logic [31:0] grant_cnt_q [N_MASTERS];
  logic [31:0] stall_cnt_q [N_MASTERS];

  // Saturating per-master handshake and stall counters.
  always_ff @(posedge clk_i) begin
    for (int m = 0; m < N_MASTERS; m++) begin
      if (rst_i) begin
        grant_cnt_q[m] <= '0;
        stall_cnt_q[m] <= '0;
      end else begin
        if (master_resp_o[m].gnt && grant_cnt_q[m] != 32'hFFFF_FFFF)
          grant_cnt_q[m] <= grant_cnt_q[m] + 32'd1;
        if (master_req_i[m].req && !master_resp_o[m].gnt && stall_cnt_q[m] != 32'hFFFF_FFFF)
          stall_cnt_q[m] <= stall_cnt_q[m] + 32'd1;
      end
    end
  end

  assign grant_cnt_o = grant_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
